lcd_frame_writer: RTL and testbench
===================================

Name: lcd_frame_writer

Overview:
Downstream consumer of the CPU debug frame: takes the 32-character, two-line text frame (256-bit ASCII bus) and the refresh strobe produced by the top-level debug logic. It drives an HD44780-compatible character LCD in 4-bit mode. It performs power-up initialisation, then rewrites both lines whenever a refresh is requested. It owns all LCD pin timing, so the frame producer needs no knowledge of the panel.

Parameters:
PWRUP_CYC, 750000, power-on wait before the first init nibble (15 ms at 50 MHz)
INIT_LONG_CYC, 205000, wait after the first 0x3 init nibble (4.1 ms)
INIT_SHORT_CYC, 5000, wait after the second and third init nibbles (100 us)
CMD_CYC, 2000, wait after each full byte (40 us)
CLEAR_CYC, 82000, wait after the clear-display command (1.64 ms)
E_HIGH_CYC, 12, lcd_e high time per nibble
NIB_GAP_CYC, 50, gap between the high and low nibble of one byte

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  reset; asynchronous, active-high
refresh  in  1  level/pulse request to redraw; sampled every clk
strdata  in  256  frame; [255:248]=line1 col0 ... [135:128]=line1 col15, [127:120]=line2 col0 ... [7:0]=line2 col15
busy  out  1  high from reset until initialisation completes and during any redraw
lcd_rs  out  1  register select (0 = command, 1 = data)
lcd_rw  out  1  constant 0 (write only)
lcd_e  out  1  enable strobe
lcd_d  out  4  data nibble

Behaviour:
- Reset (async): lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_d=0, busy=1, pending=0, state=PWRUP, all counters=0. Reset mid-operation aborts and restarts from PWRUP.
- Nibble cycle: drive lcd_rs/lcd_d → 2 clk setup → lcd_e=1 for E_HIGH_CYC clk → lcd_e=0 → 2 clk hold. lcd_rs/lcd_d change only while lcd_e=0.
- Byte: high nibble, NIB_GAP_CYC idle, low nibble, then post-wait (CMD_CYC, or CLEAR_CYC for 0x01).
- FSM: PWRUP (PWRUP_CYC) → INIT nibbles 0x3 (wait INIT_LONG), 0x3 (INIT_SHORT), 0x3 (INIT_SHORT), 0x2 (CMD_CYC); all rs=0.
- → CONFIG bytes 0x28, 0x06, 0x0C, 0x01 → IDLE (busy=0).
- IDLE: refresh=1 or pending=1 → snapshot strdata into a frame register, clear pending, busy=1 → ADDR1.
- ADDR1: cmd 0x80 → LINE1: 16 data bytes (rs=1), chars 0..15. ADDR2: cmd 0xC0 → LINE2: chars 16..31 → IDLE.
- The snapshot is taken only on redraw entry; strdata changes during a redraw do not affect the glyphs being written.
- refresh while busy (including during init): set pending. Multiple requests coalesce into one extra redraw, started immediately after the current operation finishes.
- refresh asserted continuously: back-to-back redraws with no IDLE dwell beyond 1 clk.
- Character index counter is 5 bits and wraps 31→0 only via state exit; it never indexes outside 0..31.
- Wait counters are 20 bits and must hold CLEAR_CYC and PWRUP_CYC without overflow.
- Latency from refresh in IDLE to the first lcd_e rise = 3 clk.

Decomposition:
- Shared package lcd_pkg: command constants (CMD_FUNC_4BIT=8'h28, CMD_ENTRY=8'h06, CMD_DISP_ON=8'h0C, CMD_CLEAR=8'h01, CMD_LINE1=8'h80, CMD_LINE2=8'hC0) and the top FSM state encoding.
- One sub-module, lcd_byte_tx: accepts start/rs/byte/nibble_only/post_wait and owns the nibble sequencing, E timing and post-wait. It returns a 1-clk done pulse. The top FSM only sequences bytes.

Test Plan:
Run with PWRUP_CYC=100, INIT_LONG_CYC=40, INIT_SHORT_CYC=10, CMD_CYC=8, CLEAR_CYC=30, E_HIGH_CYC=3, NIB_GAP_CYC=4.
1. Reset release, no refresh → exactly 4 lone nibbles 3,3,3,2 then bytes 28,06,0C,01 on lcd_d/e (rs=0); busy falls after the last CLEAR wait; lcd_rw=0 throughout.
2. After init, strdata="01234567 01 01  0 1 2 01        ", 1-clk refresh → busy=1; sequence 80, '0'..'7',' ','0','1',' ','0','1',' ',' ', C0, then line 2 bytes; rs=1 only for the 32 data bytes; busy=0 after.
3. Change strdata mid-redraw (after byte 5) → bytes written still match the snapshot; no extra redraw unless refresh was pulsed.
4. Three refresh pulses during one redraw → exactly one additional redraw (one more 0x80 command), then IDLE.
5. Refresh pulse during init → first redraw starts right after CONFIG 0x01 wait with no IDLE gap.
6. Assert rst during LINE2 byte 7 → outputs 0 immediately (async), busy=1; after release the full init sequence replays from PWRUP.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD frame writer: HD44780 command bytes,
// FSM state encodings and small helpers used by the top and the byte transmitter.
package lcd_pkg;

    localparam logic [7:0] CMD_FUNC_4BIT = 8'h28;
    localparam logic [7:0] CMD_ENTRY     = 8'h06;
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_LINE1     = 8'h80;
    localparam logic [7:0] CMD_LINE2     = 8'hC0;

    typedef enum logic [3:0] {
        ST_PWRUP,
        ST_INIT,
        ST_CONFIG,
        ST_IDLE,
        ST_ADDR1,
        ST_LINE1,
        ST_ADDR2,
        ST_LINE2
    } top_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_SETUP,
        TX_EHIGH,
        TX_HOLD,
        TX_GAP,
        TX_WAIT
    } tx_state_t;

    function automatic logic [7:0] config_byte(input logic [1:0] step);
        case (step)
            2'd0:    return CMD_FUNC_4BIT;
            2'd1:    return CMD_ENTRY;
            2'd2:    return CMD_DISP_ON;
            default: return CMD_CLEAR;
        endcase
    endfunction

    // Character 0 sits in the top byte of the frame, character 31 in the bottom byte.
    function automatic logic [7:0] frame_char(input logic [255:0] frame, input logic [4:0] idx);
        return frame[{~idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/lcd_byte_tx.sv
// Sends one byte (or a lone nibble) to an HD44780 in 4-bit mode, owning setup,
// E pulse width, hold, inter-nibble gap and the post-command wait.
module lcd_byte_tx
    import lcd_pkg::*;
#(
    parameter int E_HIGH_CYC  = 12,
    parameter int NIB_GAP_CYC = 50
) (
    input  logic        clk,
    input  logic        rst,
    // Handshake: start is accepted only while idle; the caller must hold off
    // until done, a 1-clk pulse issued once the post-wait has fully elapsed.
    input  logic        start,
    input  logic        rs,
    input  logic [7:0]  data,
    input  logic        nibble_only,
    input  logic [19:0] post_wait,
    output logic        lcd_rs,
    output logic        lcd_e,
    output logic [3:0]  lcd_d,
    output logic        done
);

    localparam logic [19:0] SETUP_LAST = 20'd1;
    localparam logic [19:0] HOLD_LAST  = 20'd1;
    localparam logic [19:0] E_LAST     = 20'(E_HIGH_CYC - 1);
    localparam logic [19:0] GAP_LAST   = 20'(NIB_GAP_CYC - 1);

    tx_state_t   state, state_n;
    logic [19:0] cnt, cnt_n;
    logic [19:0] wait_q, wait_n;
    logic [3:0]  low_q, low_n;
    logic        last_q, last_n;
    logic        rs_n, e_n, done_n;
    logic [3:0]  d_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= TX_IDLE;
            cnt    <= '0;
            wait_q <= '0;
            low_q  <= '0;
            last_q <= 1'b0;
            lcd_rs <= 1'b0;
            lcd_e  <= 1'b0;
            lcd_d  <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            wait_q <= wait_n;
            low_q  <= low_n;
            last_q <= last_n;
            lcd_rs <= rs_n;
            lcd_e  <= e_n;
            lcd_d  <= d_n;
            done   <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 20'd1;
        wait_n  = wait_q;
        low_n   = low_q;
        last_n  = last_q;
        rs_n    = lcd_rs;
        e_n     = lcd_e;
        d_n     = lcd_d;
        done_n  = 1'b0;
        case (state)
            TX_IDLE: begin
                cnt_n = '0;
                if (start) begin
                    rs_n    = rs;
                    d_n     = nibble_only ? data[3:0] : data[7:4];
                    low_n   = data[3:0];
                    last_n  = nibble_only;
                    wait_n  = post_wait;
                    state_n = TX_SETUP;
                end
            end
            TX_SETUP: begin
                if (cnt == SETUP_LAST) begin
                    cnt_n   = '0;
                    e_n     = 1'b1;
                    state_n = TX_EHIGH;
                end
            end
            TX_EHIGH: begin
                if (cnt == E_LAST) begin
                    cnt_n   = '0;
                    e_n     = 1'b0;
                    state_n = TX_HOLD;
                end
            end
            TX_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    cnt_n   = '0;
                    state_n = last_q ? TX_WAIT : TX_GAP;
                end
            end
            TX_GAP: begin
                // The low nibble is presented only after the gap, with E still low.
                if (cnt == GAP_LAST) begin
                    cnt_n   = '0;
                    d_n     = low_q;
                    last_n  = 1'b1;
                    state_n = TX_SETUP;
                end
            end
            TX_WAIT: begin
                if (cnt == wait_q - 20'd1) begin
                    cnt_n   = '0;
                    done_n  = 1'b1;
                    state_n = TX_IDLE;
                end
            end
            default: state_n = TX_IDLE;
        endcase
    end

endmodule

// File: rtl/lcd_frame_writer.sv
// Drives a 16x2 HD44780 panel in 4-bit mode: power-up init, then redraws both
// lines from a snapshot of the 256-bit text frame whenever refresh is requested.
module lcd_frame_writer
    import lcd_pkg::*;
#(
    parameter int PWRUP_CYC      = 750000,
    parameter int INIT_LONG_CYC  = 205000,
    parameter int INIT_SHORT_CYC = 5000,
    parameter int CMD_CYC        = 2000,
    parameter int CLEAR_CYC      = 82000,
    parameter int E_HIGH_CYC     = 12,
    parameter int NIB_GAP_CYC    = 50
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         refresh,
    input  logic [255:0] strdata,
    output logic         busy,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic         lcd_e,
    output logic [3:0]   lcd_d
);

    localparam logic [19:0] PWRUP_LAST = 20'(PWRUP_CYC - 1);
    localparam logic [19:0] LONG_W     = 20'(INIT_LONG_CYC);
    localparam logic [19:0] SHORT_W    = 20'(INIT_SHORT_CYC);
    localparam logic [19:0] CMD_W      = 20'(CMD_CYC);
    localparam logic [19:0] CLEAR_W    = 20'(CLEAR_CYC);

    top_state_t   state, state_n;
    logic [1:0]   step;
    logic [4:0]   idx;
    logic [19:0]  wait_cnt;
    logic         pending;
    logic         inflight;
    logic [255:0] frame;

    logic         tx_start, tx_rs, tx_nib, tx_done;
    logic [7:0]   tx_byte;
    logic [19:0]  tx_wait;
    logic         seq_end, take_redraw, redraw_req;

    lcd_byte_tx #(
        .E_HIGH_CYC (E_HIGH_CYC),
        .NIB_GAP_CYC(NIB_GAP_CYC)
    ) u_tx (
        .clk        (clk),
        .rst        (rst),
        .start      (tx_start),
        .rs         (tx_rs),
        .data       (tx_byte),
        .nibble_only(tx_nib),
        .post_wait  (tx_wait),
        .lcd_rs     (lcd_rs),
        .lcd_e      (lcd_e),
        .lcd_d      (lcd_d),
        .done       (tx_done)
    );

    assign busy       = (state != ST_IDLE);
    assign lcd_rw     = 1'b0;
    assign redraw_req = refresh | pending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_PWRUP;
            step     <= '0;
            idx      <= '0;
            wait_cnt <= '0;
            pending  <= 1'b0;
            inflight <= 1'b0;
            frame    <= '0;
        end else begin
            state    <= state_n;
            wait_cnt <= (state == ST_PWRUP) ? wait_cnt + 20'd1 : '0;
            if (state_n != state)
                step <= '0;
            else if (tx_done)
                step <= step + 2'd1;
            if (take_redraw) begin
                idx   <= '0;
                frame <= strdata;
            end else if (tx_done && (state == ST_LINE1 || state == ST_LINE2)) begin
                idx <= idx + 5'd1;
            end
            // Any number of requests while busy collapse into a single flag.
            if (take_redraw)
                pending <= 1'b0;
            else if (refresh)
                pending <= 1'b1;
            if (tx_done)
                inflight <= 1'b0;
            else if (tx_start)
                inflight <= 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        tx_rs   = 1'b0;
        tx_byte = 8'h00;
        tx_nib  = 1'b0;
        tx_wait = CMD_W;
        seq_end = 1'b0;
        case (state)
            ST_PWRUP: begin
                if (wait_cnt == PWRUP_LAST) state_n = ST_INIT;
            end
            ST_INIT: begin
                tx_nib  = 1'b1;
                tx_byte = (step == 2'd3) ? 8'h02 : 8'h03;
                tx_wait = (step == 2'd0) ? LONG_W : (step == 2'd3) ? CMD_W : SHORT_W;
                if (tx_done && step == 2'd3) state_n = ST_CONFIG;
            end
            ST_CONFIG: begin
                tx_byte = config_byte(step);
                tx_wait = (tx_byte == CMD_CLEAR) ? CLEAR_W : CMD_W;
                if (tx_done && step == 2'd3) seq_end = 1'b1;
            end
            ST_IDLE: begin
                if (redraw_req) state_n = ST_ADDR1;
            end
            ST_ADDR1: begin
                tx_byte = CMD_LINE1;
                if (tx_done) state_n = ST_LINE1;
            end
            ST_LINE1: begin
                tx_rs   = 1'b1;
                tx_byte = frame_char(frame, idx);
                if (tx_done && idx == 5'd15) state_n = ST_ADDR2;
            end
            ST_ADDR2: begin
                tx_byte = CMD_LINE2;
                if (tx_done) state_n = ST_LINE2;
            end
            ST_LINE2: begin
                tx_rs   = 1'b1;
                tx_byte = frame_char(frame, idx);
                if (tx_done && idx == 5'd31) seq_end = 1'b1;
            end
            default: state_n = ST_PWRUP;
        endcase
        // A queued request chains straight into the next redraw without visiting IDLE.
        if (seq_end) state_n = redraw_req ? ST_ADDR1 : ST_IDLE;
        take_redraw = (state_n == ST_ADDR1) && (state != ST_ADDR1);
        tx_start    = (state != ST_PWRUP) && (state != ST_IDLE) && !inflight;
    end

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Directed bench for lcd_frame_writer: decodes the LCD pins into {rs,nibble}
// records and checks them against hand-built init and redraw sequences.
module tb_lcd_frame_writer;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         refresh = 1'b0;
    logic [255:0] strdata = '0;
    logic         busy, lcd_rs, lcd_rw, lcd_e;
    logic [3:0]   lcd_d;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] nib_q[$];

    int           cyc = 0;
    int           stab_err = 0;
    int           busy_falls = 0;
    int           efall_cyc = 0;
    int           bfall_cyc = 0;
    logic         prev_e = 1'b0;
    logic         prev_busy = 1'b1;
    logic [W-1:0] prev_bus = '0;

    logic [255:0] frame_a, frame_b, frame_c;
    int           bf0;

    lcd_frame_writer #(
        .PWRUP_CYC     (100),
        .INIT_LONG_CYC (40),
        .INIT_SHORT_CYC(10),
        .CMD_CYC       (8),
        .CLEAR_CYC     (30),
        .E_HIGH_CYC    (3),
        .NIB_GAP_CYC   (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .refresh(refresh),
        .strdata(strdata),
        .busy   (busy),
        .lcd_rs (lcd_rs),
        .lcd_rw (lcd_rw),
        .lcd_e  (lcd_e),
        .lcd_d  (lcd_d)
    );

    always #5 clk = ~clk;

    // Pin monitor: one record per E rise, plus bus-stability and busy-edge tracking.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (lcd_e && !prev_e) nib_q.push_back({lcd_rs, lcd_d});
        if (lcd_e && prev_e && ({lcd_rs, lcd_d} !== prev_bus)) stab_err <= stab_err + 1;
        if (lcd_rw !== 1'b0) stab_err <= stab_err + 1;
        if (!lcd_e && prev_e) efall_cyc <= cyc;
        if (prev_busy && !busy) begin
            busy_falls <= busy_falls + 1;
            bfall_cyc  <= cyc;
        end
        prev_e    <= lcd_e;
        prev_busy <= busy;
        prev_bus  <= {lcd_rs, lcd_d};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic rs, input logic [7:0] b);
        exp_q.push_back({rs, b[7:4]});
        exp_q.push_back({rs, b[3:0]});
    endtask

    task automatic push_init();
        exp_q.push_back(5'h03);
        exp_q.push_back(5'h03);
        exp_q.push_back(5'h03);
        exp_q.push_back(5'h02);
        push_byte(1'b0, 8'h28);
        push_byte(1'b0, 8'h06);
        push_byte(1'b0, 8'h0C);
        push_byte(1'b0, 8'h01);
    endtask

    task automatic push_redraw(input logic [255:0] f);
        push_byte(1'b0, 8'h80);
        for (int k = 0; k < 16; k++) push_byte(1'b1, f[255 - 8*k -: 8]);
        push_byte(1'b0, 8'hC0);
        for (int k = 16; k < 32; k++) push_byte(1'b1, f[255 - 8*k -: 8]);
    endtask

    task automatic compare_q(input string tag);
        int i = 0;
        chk({tag, " count"}, nib_q.size(), exp_q.size());
        while (nib_q.size() > 0 && exp_q.size() > 0) begin
            chk($sformatf("%s nib%0d", tag, i), nib_q.pop_front(), exp_q.pop_front());
            i++;
        end
        nib_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_busy(input logic level, input int budget, input string tag);
        int k = 0;
        while (busy !== level && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " busy wait"}, busy, level);
        @(negedge clk);
    endtask

    task automatic wait_nibs(input int n, input int budget, input string tag);
        int k = 0;
        while (nib_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " nibble wait"}, 32'(nib_q.size() >= n), 32'd1);
    endtask

    task automatic pulse_refresh();
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
    endtask

    initial begin
        frame_a = "01234567 01 01  0 1 2 01        ";
        frame_b = "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdef";
        frame_c = "hello world     second line 2...";

        // Reset values while rst is held.
        repeat (3) @(negedge clk);
        chk("rst lcd_e", lcd_e, 1'b0);
        chk("rst lcd_d", lcd_d, 4'h0);
        chk("rst lcd_rs", lcd_rs, 1'b0);
        chk("rst lcd_rw", lcd_rw, 1'b0);
        chk("rst busy", busy, 1'b1);
        rst = 1'b0;

        // Power-up init: four lone nibbles then four config bytes.
        push_init();
        wait_busy(1'b0, 1500, "init");
        compare_q("init");
        chk("clear wait to busy fall", bfall_cyc - efall_cyc, 33);

        // First redraw, with refresh-to-E latency.
        strdata = frame_a;
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
        chk("redraw busy", busy, 1'b1);
        chk("lat0 lcd_e", lcd_e, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("lat2 lcd_e", lcd_e, 1'b0);
        @(negedge clk);
        chk("lat3 lcd_e", lcd_e, 1'b1);
        push_redraw(frame_a);
        wait_busy(1'b0, 2000, "redraw");
        compare_q("redraw");

        // Frame changes mid-redraw must not reach the panel.
        bf0 = busy_falls;
        strdata = frame_b;
        pulse_refresh();
        wait_nibs(12, 1000, "snapshot");
        strdata = frame_a;
        push_redraw(frame_b);
        wait_busy(1'b0, 2000, "snapshot");
        repeat (60) @(negedge clk);
        chk("snapshot idle busy", busy, 1'b0);
        compare_q("snapshot");
        chk("snapshot busy falls", busy_falls - bf0, 1);

        // Three requests during one redraw coalesce into exactly one more.
        bf0 = busy_falls;
        strdata = frame_c;
        pulse_refresh();
        wait_nibs(4, 1000, "coalesce a");
        pulse_refresh();
        wait_nibs(20, 1000, "coalesce b");
        pulse_refresh();
        wait_nibs(40, 1000, "coalesce c");
        pulse_refresh();
        push_redraw(frame_c);
        push_redraw(frame_c);
        wait_busy(1'b0, 4000, "coalesce");
        repeat (60) @(negedge clk);
        compare_q("coalesce");
        chk("coalesce busy falls", busy_falls - bf0, 1);

        // Refresh during power-up chains into a redraw with no idle gap.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        nib_q.delete();
        rst = 1'b0;
        bf0 = busy_falls;
        strdata = frame_b;
        repeat (10) @(negedge clk);
        pulse_refresh();
        push_init();
        push_redraw(frame_b);
        wait_busy(1'b0, 4000, "init refresh");
        repeat (20) @(negedge clk);
        compare_q("init refresh");
        chk("init refresh busy falls", busy_falls - bf0, 1);

        // Async reset while E is high on line-2 character 7.
        strdata = frame_a;
        pulse_refresh();
        wait_nibs(51, 2000, "abort");
        chk("abort pre lcd_e", lcd_e, 1'b1);
        chk("abort pre lcd_rs", lcd_rs, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("abort lcd_e", lcd_e, 1'b0);
        chk("abort lcd_d", lcd_d, 4'h0);
        chk("abort lcd_rs", lcd_rs, 1'b0);
        chk("abort busy", busy, 1'b1);
        repeat (3) @(negedge clk);
        nib_q.delete();
        rst = 1'b0;
        push_init();
        wait_busy(1'b0, 1500, "replay");
        compare_q("replay");

        chk("bus stable while E high and rw low", stab_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
